countdown_timer: RTL

- BCD mm:ss countdown timer. It is the down-counting counterpart of the up-counting watch datapath.
- Software or the button front-end loads a start time, then starts, pauses and resumes it.
- Decrements once per `tick` enable and flags expiry.
- Its outputs feed the same 4-digit display mux as the watch digits.

---
 rtl/countdown_timer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer: load, start/pause/resume, decrement on each 1 Hz tick, flag expiry.
// Digit outputs share the 4-digit display mux with the watch datapath.
module countdown_timer #(
    parameter int MIN_TENS_MAX = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start_resume,
    input  logic       stop,
    input  logic       setTime,
    input  logic [3:0] set_min1,
    input  logic [3:0] set_min0,
    input  logic [3:0] set_sec1,
    input  logic [3:0] set_sec0,
    output logic [3:0] min1,
    output logic [3:0] min0,
    output logic [3:0] sec1,
    output logic [3:0] sec0,
    output logic       running,
    output logic       expired,
    output logic       timeup,
    output logic       load_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAUSED  = 2'd1,
        ST_RUN     = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] MIN1_LIM = 4'(MIN_TENS_MAX);

    state_t     state_q;
    logic [3:0] min1_q, min0_q, sec1_q, sec0_q;
    logic       running_q, expired_q, timeup_q, load_err_q;

    logic [3:0] min1_d, min0_d, sec1_d, sec0_d;
    logic       borrow0_s, borrow1_s, borrow2_s;
    logic       dec_zero_s, load_ok_s, load_zero_s;

    // Load validation and the decremented value of the current digits (borrow chain).
    always_comb begin
        load_ok_s   = (set_min1 <= MIN1_LIM) && (set_min0 <= 4'd9) &&
                      (set_sec1 <= 4'd5)     && (set_sec0 <= 4'd9);
        load_zero_s = (set_min1 == 4'd0) && (set_min0 == 4'd0) &&
                      (set_sec1 == 4'd0) && (set_sec0 == 4'd0);

        borrow0_s = (sec0_q == 4'd0);
        borrow1_s = borrow0_s && (sec1_q == 4'd0);
        borrow2_s = borrow1_s && (min0_q == 4'd0);

        sec0_d = borrow0_s ? 4'd9 : (sec0_q - 4'd1);
        sec1_d = borrow0_s ? ((sec1_q == 4'd0) ? 4'd5 : (sec1_q - 4'd1)) : sec1_q;
        min0_d = borrow1_s ? ((min0_q == 4'd0) ? 4'd9 : (min0_q - 4'd1)) : min0_q;
        min1_d = borrow2_s ? (min1_q - 4'd1) : min1_q;

        dec_zero_s = (min1_d == 4'd0) && (min0_d == 4'd0) &&
                     (sec1_d == 4'd0) && (sec0_d == 4'd0);
    end

    // Control FSM with digit registers and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            min1_q     <= 4'd0;
            min0_q     <= 4'd0;
            sec1_q     <= 4'd0;
            sec0_q     <= 4'd0;
            running_q  <= 1'b0;
            expired_q  <= 1'b0;
            timeup_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            timeup_q   <= 1'b0;
            load_err_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    // setTime is ignored while counting; stop outranks tick.
                    if (stop) begin
                        state_q   <= ST_PAUSED;
                        running_q <= 1'b0;
                    end else if (tick) begin
                        min1_q <= min1_d;
                        min0_q <= min0_d;
                        sec1_q <= sec1_d;
                        sec0_q <= sec0_d;
                        if (dec_zero_s) begin
                            state_q   <= ST_EXPIRED;
                            running_q <= 1'b0;
                            expired_q <= 1'b1;
                            timeup_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_IDLE, ST_PAUSED, ST_EXPIRED: begin
                    if (setTime) begin
                        if (load_ok_s) begin
                            min1_q    <= set_min1;
                            min0_q    <= set_min0;
                            sec1_q    <= set_sec1;
                            sec0_q    <= set_sec0;
                            state_q   <= load_zero_s ? ST_IDLE : ST_PAUSED;
                            running_q <= 1'b0;
                            expired_q <= 1'b0;
                        end else begin
                            load_err_q <= 1'b1;
                        end
                    end else if ((state_q == ST_PAUSED) && start_resume) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end else begin
                        state_q <= state_q;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                    expired_q <= 1'b0;
                end
            endcase
        end
    end

    assign min1     = min1_q;
    assign min0     = min0_q;
    assign sec1     = sec1_q;
    assign sec0     = sec0_q;
    assign running  = running_q;
    assign expired  = expired_q;
    assign timeup   = timeup_q;
    assign load_err = load_err_q;

endmodule
